// File: rtl/sym_seq_pkg.sv
// Shared types for the symbol sequencer: inner walk-FSM encodings,
// controller states and the walk transition function.
package sym_seq_pkg;

    typedef enum logic [1:0] {
        ST0 = 2'b00,
        ST1 = 2'b01,
        ST2 = 2'b10,
        ST3 = 2'b11
    } walk_st_t;

    typedef enum logic [1:0] {
        CTL_IDLE = 2'b00,
        CTL_RUN  = 2'b01,
        CTL_DONE = 2'b10
    } ctl_st_t;

    // Next walk state for current state and input symbol; s=0 always holds
    // (except from ST3, which always falls back to ST0).
    function automatic walk_st_t walk_next(input walk_st_t cur, input logic [1:0] s);
        walk_st_t n;
        n = cur;
        case (cur)
            ST0: if (s == 2'd1) n = ST1; else if (s != 2'd0) n = ST2;
            ST1: if (s == 2'd3) n = ST3; else if (s != 2'd0) n = ST2;
            ST2: if (s != 2'd0) n = ST3;
            default: n = ST0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sym_walk_fsm.sv
// Inner walk FSM: consumes one 2-bit symbol per cycle; clr forces ST0.
module sym_walk_fsm
    import sym_seq_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       clr,
    input  logic [1:0] s,
    output logic [1:0] state
);

    walk_st_t r_st;
    walk_st_t w_nxt;

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) r_st <= ST0;
        else      r_st <= w_nxt;
    end

    // Next state: clear has priority over the symbol-driven transition
    always_comb begin
        w_nxt = walk_next(r_st, s);
        if (clr) w_nxt = ST0;
    end

    assign state = r_st;

endmodule

// File: rtl/sym_seq_ctrl.sv
// Symbol sequencer: a DEPTH-entry symbol buffer drained one symbol per
// cycle into the walk FSM during a run started by 'start'.
// Optional macro SYM_SEQ_AUTOCLR_EN: an accepted start resets the walk FSM
// to ST0 so every run begins from a known state.
module sym_seq_ctrl
    import sym_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     wr_en,
    input  logic [1:0]               wr_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               result,
    output logic [1:0]               fsm_state,
    output logic [CNT_W-1:0]         hits,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]    LVL_ONE  = (AW+1)'(1);

    logic [1:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_level;
    ctl_st_t          r_ctl, w_ctl_nxt;
    logic [1:0]       r_result;
    logic [CNT_W-1:0] r_hits;
    logic             r_ovf;

    logic             w_pop, w_push, w_full, w_ovf_ev, w_start, w_last, w_clr;
    logic             w_enter_st3;
    logic [1:0]       w_s, w_walk;

    assign w_full   = (r_level == LVL_FULL);
    assign w_pop    = (r_ctl == CTL_RUN) && (r_level != '0);
    // A pop frees a slot in the same cycle, so a full buffer still accepts.
    assign w_push   = wr_en && (!w_full || w_pop);
    assign w_ovf_ev = wr_en && w_full && !w_pop;
    assign w_start  = (r_ctl == CTL_IDLE) && start && (r_level != '0);
    assign w_last   = w_pop && !w_push && (r_level == LVL_ONE);
    assign w_s      = w_pop ? r_mem[r_rp] : 2'b00;

`ifdef SYM_SEQ_AUTOCLR_EN
    assign w_clr = w_start;
`else
    assign w_clr = 1'b0;
`endif

    // ST3 always exits, so next==ST3 is exactly an entry into ST3
    assign w_enter_st3 = !w_clr && (walk_next(walk_st_t'(w_walk), w_s) == ST3);

    sym_walk_fsm u_walk (
        .clk   (clk),
        .res   (res),
        .clr   (w_clr),
        .s     (w_s),
        .state (w_walk)
    );

    // Buffer storage; contents are don't-care while level is 0
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= wr_data;
    end

    // Buffer pointers and occupancy; pointers wrap naturally at 2^AW = DEPTH
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Controller state register
    always_ff @(posedge clk or negedge res) begin
        if (!res) r_ctl <= CTL_IDLE;
        else      r_ctl <= w_ctl_nxt;
    end

    // Controller next state: run until the pop that empties the buffer
    always_comb begin
        w_ctl_nxt = r_ctl;
        case (r_ctl)
            CTL_IDLE: if (w_start) w_ctl_nxt = CTL_RUN;
            CTL_RUN:  if (w_last)  w_ctl_nxt = CTL_DONE;
            default:               w_ctl_nxt = CTL_IDLE;
        endcase
    end

    // Run status: result capture, saturating ST3 counter, sticky overflow
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_result <= '0;
            r_hits   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (r_ctl == CTL_DONE) r_result <= w_walk;
            if (w_start)                         r_hits <= '0;
            else if (w_enter_st3 && r_hits != '1) r_hits <= r_hits + 1'b1;
            if (w_ovf_ev)     r_ovf <= 1'b1;
            else if (w_start) r_ovf <= 1'b0;
        end
    end

    assign busy      = (r_ctl == CTL_RUN);
    assign done      = (r_ctl == CTL_DONE);
    assign result    = r_result;
    assign fsm_state = w_walk;
    assign hits      = r_hits;
    assign ovf       = r_ovf;
    assign level     = r_level;

endmodule

// File: tb/tb_sym_seq_ctrl.sv
// Self-checking bench for sym_seq_ctrl: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_sym_seq_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int HMAX  = (1 << CNT_W) - 1;
`ifdef SYM_SEQ_AUTOCLR_EN
    localparam bit AUTOCLR = 1'b1;
`else
    localparam bit AUTOCLR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             res, wr_en, start;
    logic [1:0]       wr_data;
    logic             busy, done, ovf;
    logic [1:0]       result, fsm_state;
    logic [CNT_W-1:0] hits;
    logic [$clog2(DEPTH):0] level;

    sym_seq_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .res(res), .wr_en(wr_en), .wr_data(wr_data), .start(start),
        .busy(busy), .done(done), .result(result), .fsm_state(fsm_state),
        .hits(hits), .ovf(ovf), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: symbol queue, run/done flags, walk state as integer
    int q[$];
    int m_walk, m_res, m_hits;
    bit m_busy, m_done, m_ovf;
    int tbl [4][4] = '{'{0, 1, 2, 2}, '{1, 2, 2, 3}, '{2, 3, 3, 3}, '{0, 0, 0, 0}};

    task automatic model_reset();
        q.delete();
        m_walk = 0; m_res = 0; m_hits = 0;
        m_busy = 0; m_done = 0; m_ovf = 0;
    endtask

    // Drive one cycle of inputs and advance the model across the edge
    task automatic cyc(input bit we, input int wd, input bit st);
        bit pop, acc, push_ok, ovfev;
        int sym, nw, sz;
        @(negedge clk);
        wr_en = we; wr_data = wd[1:0]; start = st;
        @(posedge clk);
        sz      = q.size();
        pop     = m_busy && sz > 0;
        acc     = !m_busy && !m_done && st && sz > 0;
        sym     = pop ? q[0] : 0;
        nw      = (AUTOCLR && acc) ? 0 : tbl[m_walk][sym];
        push_ok = we && (sz < DEPTH || pop);
        ovfev   = we && sz == DEPTH && !pop;
        if (acc) m_hits = 0;
        else if (nw == 3 && m_walk != 3 && m_hits < HMAX) m_hits++;
        if (ovfev) m_ovf = 1; else if (acc) m_ovf = 0;
        if (m_done) m_res = m_walk;
        m_walk = nw;
        if (pop) void'(q.pop_front());
        if (push_ok) q.push_back(wd & 3);
        if (m_done) m_done = 0;
        else if (pop && q.size() == 0) begin m_busy = 0; m_done = 1; end
        else if (acc) m_busy = 1;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 0; wr_en = 0; start = 0; wr_data = 0;
        @(negedge clk);
        res = 1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        res = 0; wr_en = 1; wr_data = 2'd1; start = 1;
        @(posedge clk); #1;
        checks++; if ({busy, done, ovf} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {busy, done, ovf}); end
        checks++; if (level !== 0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", fsm_state); end
        checks++; if (result !== 2'd0 || hits !== 0) begin errors++; $display("FAIL rst_res_hits got %0d/%0d want 0/0", result, hits); end
        @(negedge clk);
        res = 1; wr_en = 0; start = 0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_basic_run();
        int es[3] = '{1, 2, 3};
        do_reset();
        cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 3, 0);
        cyc(0, 0, 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b1_busy_start got %b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            checks++; if (fsm_state !== es[i][1:0]) begin errors++; $display("FAIL b1_state%0d got %0d want %0d", i, fsm_state, es[i]); end
            checks++; if (busy !== (i < 2)) begin errors++; $display("FAIL b1_busy%0d got %b want %b", i, busy, i < 2); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b1_done got %b want 1", done); end
        cyc(0, 0, 0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b1_done_pulse got %b want 0", done); end
        checks++; if (result !== 2'd3) begin errors++; $display("FAIL b1_result got %0d want 3", result); end
        checks++; if (hits !== 1) begin errors++; $display("FAIL b1_hits got %0d want 1", hits); end
    endtask

    task automatic test_hold_run();
        int es[4] = '{2, 2, 2, 3};
        int n;
        do_reset();
        cyc(1, 2, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0);
        cyc(0, 0, 1);
        n = busy ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0);
            checks++; if (fsm_state !== es[i][1:0]) begin errors++; $display("FAIL b2_state%0d got %0d want %0d", i, fsm_state, es[i]); end
            if (busy) n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL b2_busy_cycles got %0d want 4", n); end
        cyc(0, 0, 0);
        checks++; if (result !== 2'd3 || hits !== 1) begin errors++; $display("FAIL b2_res_hits got %0d/%0d want 3/1", result, hits); end
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 1, 0);
        cyc(1, 3, 0);
        checks++; if (level !== 4) begin errors++; $display("FAIL ov_level got %0d want 4", level); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ov_flag got %b want 1", ovf); end
        // start with a simultaneous dropped push: overflow wins over the clear
        cyc(1, 2, 1);
        checks++; if (ovf !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ov_win got ovf=%b busy=%b want 1 1", ovf, busy); end
        n = 1;
        for (int i = 0; i < 10 && !done; i++) begin cyc(0, 0, 0); if (busy) n++; end
        checks++; if (n !== 4 || done !== 1'b1) begin errors++; $display("FAIL ov_runlen got %0d done=%b want 4 1", n, done); end
        cyc(0, 0, 0);
        checks++; if (result !== 2'd0) begin errors++; $display("FAIL ov_result got %0d want 0", result); end
        cyc(1, 1, 0); cyc(0, 0, 1);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ov_clear got %b want 0", ovf); end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    endtask

    task automatic test_empty_start_and_extend();
        int n;
        bit sawdone;
        do_reset();
        cyc(0, 0, 1);
        sawdone = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL es_busy got %b want 0", busy); end
            if (done) sawdone = 1;
            cyc(0, 0, 0);
        end
        checks++; if (sawdone) begin errors++; $display("FAIL es_done got 1 want 0"); end
        cyc(1, 1, 0); cyc(1, 2, 0); cyc(0, 0, 1);
        n = busy ? 1 : 0;
        cyc(1, 3, 0);
        if (busy) n++;
        checks++; if (level !== 2) begin errors++; $display("FAIL ex_level got %0d want 2", level); end
        for (int i = 0; i < 10 && !done; i++) begin cyc(0, 0, 0); if (busy) n++; end
        checks++; if (n !== 3 || done !== 1'b1) begin errors++; $display("FAIL ex_runlen got %0d done=%b want 3 1", n, done); end
        cyc(0, 0, 0);
        checks++; if (result !== m_res[1:0]) begin errors++; $display("FAIL ex_result got %0d want %0d", result, m_res); end
    endtask

    task automatic test_reset_mid_run();
        bit sawdone;
        do_reset();
        cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 3, 0); cyc(0, 0, 1);
        cyc(0, 0, 0);
        @(negedge clk);
        res = 0;
        #1;
        checks++; if (busy !== 1'b0 || level !== 0) begin errors++; $display("FAIL mr_abort got busy=%b level=%0d want 0 0", busy, level); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL mr_state got %0d want 0", fsm_state); end
        @(negedge clk);
        res = 1;
        model_reset();
        @(posedge clk); #1;
        sawdone = 0;
        for (int i = 0; i < 5; i++) begin cyc(0, 0, 0); if (done || busy) sawdone = 1; end
        checks++; if (sawdone) begin errors++; $display("FAIL mr_nodone got activity want none"); end
    endtask

    task automatic test_run_to_run();
        do_reset();
        cyc(1, 1, 0); cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 0);
        checks++; if (result !== 2'd1) begin errors++; $display("FAIL rr_first got %0d want 1", result); end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        cyc(1, 1, 0); cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 0);
        checks++; if (result !== (AUTOCLR ? 2'd1 : 2'd2)) begin errors++; $display("FAIL rr_second got %0d want %0d", result, AUTOCLR ? 1 : 2); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 3, 0);
        cyc(0, 0, 1);
        for (int i = 0; i < 60; i++) cyc(1, 3, 0);
        checks++; if (hits !== 4'(HMAX)) begin errors++; $display("FAIL sat_hits got %0d want %0d", hits, HMAX); end
        for (int i = 0; i < 10 && !done; i++) cyc(0, 0, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sat_timeout got done=%b want 1", done); end
        cyc(0, 0, 0);
        checks++; if (hits !== 4'(HMAX)) begin errors++; $display("FAIL sat_hold got %0d want %0d", hits, HMAX); end
        cyc(1, 1, 0); cyc(0, 0, 1);
        checks++; if (hits !== 0) begin errors++; $display("FAIL sat_clear got %0d want 0", hits); end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 99) < 55, int'($urandom_range(0, 3)), $urandom_range(0, 99) < 25);
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy c%0d got %b want %b", i, busy, m_busy); end
            checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done c%0d got %b want %b", i, done, m_done); end
            checks++; if (fsm_state !== m_walk[1:0]) begin errors++; $display("FAIL rnd_state c%0d got %0d want %0d", i, fsm_state, m_walk); end
            checks++; if (level !== q.size()) begin errors++; $display("FAIL rnd_level c%0d got %0d want %0d", i, level, q.size()); end
            checks++; if (hits !== m_hits[CNT_W-1:0]) begin errors++; $display("FAIL rnd_hits c%0d got %0d want %0d", i, hits, m_hits); end
            checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d got %b want %b", i, ovf, m_ovf); end
            checks++; if (result !== m_res[1:0]) begin errors++; $display("FAIL rnd_result c%0d got %0d want %0d", i, result, m_res); end
        end
    endtask

    initial begin
        res = 0; wr_en = 0; start = 0; wr_data = 0;
        model_reset();
        test_reset();
        test_basic_run();
        test_hold_run();
        test_overflow();
        test_empty_start_and_extend();
        test_reset_mid_run();
        test_run_to_run();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
